// File: rtl/proc_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit, 8-register core.
// Define ILLEGAL_OP_TRAP_EN to trap opcode 010 into HALT with a sticky illegal_op.
module proc_control_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [15:0]      imem_addr,
  input  logic [15:0]      imem_instr,
  output logic [2:0]       rf_raddr_a,
  output logic [2:0]       rf_raddr_b,
  input  logic             rd_zero,
  output logic             rf_we,
  output logic [2:0]       rf_waddr,
  output logic [1:0]       wb_sel,
  output logic             alu_op,
  output logic [15:0]      imm_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] retired
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic             illegal_op
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic [2:0]  op;
  logic [15:0] sx, pc_inc;
  logic is_add, is_sub, is_ill, is_hlt;
  logic is_out, is_ldi, is_bne, is_jr;

  assign op     = ir_q[15:13];
  assign sx     = {{6{ir_q[9]}}, ir_q[9:0]};
  assign pc_inc = pc_q + 16'd1;

  assign is_add = (op == 3'b000);
  assign is_sub = (op == 3'b001);
  assign is_ill = (op == 3'b010);
  assign is_hlt = (op == 3'b011);
  assign is_out = (op == 3'b100);
  assign is_ldi = (op == 3'b101);
  assign is_bne = (op == 3'b110);
  assign is_jr  = (op == 3'b111);

  assign imem_addr  = pc_q;
  assign rf_raddr_a = ir_q[12:10];
  assign rf_raddr_b = ir_q[9:7];
  assign rf_waddr   = ir_q[12:10];
  assign imm_out    = {6'b0, ir_q[9:0]};
  assign retired    = ret_q;
  assign halted     = (state_q == S_HALT);
  assign busy       = (state_q == S_FETCH) ||
                      (state_q == S_DECODE) ||
                      (state_q == S_EXEC);

`ifdef ILLEGAL_OP_TRAP_EN
  logic ill_q, ill_d;
  assign illegal_op = ill_q;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ret_d     = ret_q;
    rf_we     = 1'b0;
    out_valid = 1'b0;
    wb_sel    = 2'b00;
    alu_op    = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    ill_d     = ill_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = imem_instr;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // Common retire path; non-retiring cases override it.
        state_d = S_FETCH;
        pc_d    = pc_inc;
        ret_d   = ret_q + CNT_ONE;
        unique case (1'b1)
          is_add: rf_we = 1'b1;
          is_sub: begin
            rf_we  = 1'b1;
            alu_op = 1'b1;
          end
          is_ill: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_d = S_HALT;
            pc_d    = pc_q;
            ret_d   = ret_q;
            ill_d   = 1'b1;
`else
            pc_d    = pc_inc;
`endif
          end
          is_hlt: begin
            state_d = S_HALT;
            pc_d    = pc_q;
            ret_d   = ret_q;
          end
          is_out: begin
            out_valid = 1'b1;
            if (!out_ready) begin
              state_d = S_EXEC;
              pc_d    = pc_q;
              ret_d   = ret_q;
            end
          end
          is_ldi: begin
            rf_we  = 1'b1;
            wb_sel = 2'b01;
          end
          is_bne: begin
            if (rd_zero) pc_d = pc_inc + sx;
          end
          is_jr: begin
            if (ir_q[12:10] == 3'd0) begin
              pc_d = pc_q + sx;
            end else begin
              rf_we  = 1'b1;
              wb_sel = 2'b10;
            end
          end
          default: ;
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      ret_q   <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
`ifdef ILLEGAL_OP_TRAP_EN
      ill_q   <= ill_d;
`endif
    end
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit: ISA-level reference model plus a small
// register-file datapath, directed programs and random instruction streams.
module tb_proc_control_unit;

  localparam logic [15:0] RPC = 16'h0000;

  logic        clk, rst, start;
  logic [15:0] imem_addr, imem_instr;
  logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic        rd_zero, rf_we, alu_op;
  logic [1:0]  wb_sel;
  logic [15:0] imm_out;
  logic        out_valid, out_ready, halted, busy;
  logic [15:0] retired;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        illegal_op;
`endif

  proc_control_unit #(.RESET_PC(RPC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rd_zero(rd_zero), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .wb_sel(wb_sel), .alu_op(alu_op), .imm_out(imm_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .busy(busy), .retired(retired)
`ifdef ILLEGAL_OP_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] imem [65536];
  assign imem_instr = imem[imem_addr];

  // environment datapath driven by the DUT strobes
  logic [15:0] dp [8];
  logic        dp_clr;
  logic [15:0] dpa, dpb;
  assign dpa     = dp[rf_raddr_a];
  assign dpb     = dp[rf_raddr_b];
  assign rd_zero = (dpa == 16'h0);

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int i = 0; i < 8; i++) dp[i] <= 16'h0;
    end else if (rf_we) begin
      if (wb_sel == 2'b00) dp[rf_waddr] <= alu_op ? dpa - dpb : dpa + dpb;
      else if (wb_sel == 2'b01) dp[rf_waddr] <= imm_out;
      else dp[rf_waddr] <= dpb;
    end
  end

  int n_chk, n_fail;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ISA-level reference state
  logic [15:0] regs_m [8];
  logic [15:0] pc_m, ret_m, last_out;
  logic        halt_m, ill_m, out_seen;

  function automatic logic [15:0] enc_r(input logic [2:0] op,
      input logic [2:0] rd, input logic [2:0] rs);
    return {op, rd, rs, 7'b0};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op,
      input logic [2:0] rd, input logic [9:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic chk_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_we"}, rf_we, 0);
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_wbsel"}, wb_sel, 0);
    check({tag, "_aluop"}, alu_op, 0);
    check({tag, "_retired"}, retired, 0);
    check({tag, "_pc"}, imem_addr, RPC);
`ifdef ILLEGAL_OP_TRAP_EN
    check({tag, "_illegal"}, illegal_op, 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; dp_clr = 1'b1;
    @(negedge clk);
    rst = 1'b0; dp_clr = 1'b0;
    chk_reset_vals("reset");
    for (int i = 0; i < 8; i++) regs_m[i] = 16'h0;
    pc_m = RPC; ret_m = 16'h0; halt_m = 1'b0; ill_m = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pc_m = RPC;
  endtask

  // Entered at the negedge of the FETCH cycle; leaves at the next FETCH or HALT.
  task automatic step_instr(input int wait_n);
    logic [15:0] ins, a, b, sx, nxt, wval;
    logic [2:0]  op, rd, rs;
    logic        we, is_out, is_halt, r;
    logic [1:0]  wsel;
    check("fetch_pc", imem_addr, pc_m);
    check("fetch_busy", busy, 1);
    check("fetch_ret", retired, ret_m);
    ins = imem[pc_m];
    op = ins[15:13]; rd = ins[12:10]; rs = ins[9:7];
    sx = {{6{ins[9]}}, ins[9:0]};
    a = regs_m[rd]; b = regs_m[rs];
    nxt = pc_m + 16'd1; wval = 16'h0; wsel = 2'b00;
    we = 1'b0; is_out = 1'b0; is_halt = 1'b0;
    case (op)
      3'd0: begin we = 1; wval = a + b; end
      3'd1: begin we = 1; wval = a - b; end
      3'd2: begin
`ifdef ILLEGAL_OP_TRAP_EN
        is_halt = 1; nxt = pc_m; ill_m = 1;
`endif
      end
      3'd3: begin is_halt = 1; nxt = pc_m; end
      3'd4: is_out = 1;
      3'd5: begin we = 1; wsel = 2'b01; wval = {6'b0, ins[9:0]}; end
      3'd6: if (a == 16'h0) nxt = pc_m + 16'd1 + sx;
      default: begin
        if (rd == 3'd0) nxt = pc_m + sx;
        else begin we = 1; wsel = 2'b10; wval = b; end
      end
    endcase
    @(negedge clk);
    check("dec_we", rf_we, 0);
    check("dec_ov", out_valid, 0);
    @(negedge clk);
    check("exec_ra", rf_raddr_a, rd);
    check("exec_rb", rf_raddr_b, rs);
    check("exec_we", rf_we, we);
    if (we) begin
      check("exec_waddr", rf_waddr, rd);
      check("exec_wbsel", wb_sel, wsel);
    end
    if (op <= 3'd1) check("exec_aluop", alu_op, op[0]);
    out_seen = is_out;
    if (is_out) begin
      last_out = a;
      for (int n = 0; n <= wait_n; n++) begin
        check("out_valid", out_valid, 1);
        check("out_data", dpa, a);
        check("out_pc", imem_addr, pc_m);
        check("out_ret", retired, ret_m);
        check("out_we", rf_we, 0);
        r = (n == wait_n);
        out_ready = r;
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
      end
    end else begin
      check("exec_ov", out_valid, 0);
      @(negedge clk);
    end
    if (we) begin
      regs_m[rd] = wval;
      check("wb_data", dp[rd], wval);
    end
    pc_m = nxt;
    if (is_halt) begin
      halt_m = 1'b1;
      check("halt_flag", halted, 1);
      check("halt_busy", busy, 0);
      check("halt_pc", imem_addr, pc_m);
      check("halt_ret", retired, ret_m);
`ifdef ILLEGAL_OP_TRAP_EN
      check("halt_illegal", illegal_op, ill_m);
`endif
    end else begin
      ret_m = ret_m + 16'd1;
    end
  endtask

  task automatic fill_mem(input logic [15:0] w);
    for (int i = 0; i < 65536; i++) imem[i] = w;
  endtask

  logic [15:0] outs [$];
  int          first_out;

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; dp_clr = 1'b1;
    repeat (2) @(negedge clk);

    // Counting loop: out 1..5, then halt at 0x0009
    fill_mem({3'b011, 13'h0});
    imem[0] = enc_i(3'b101, 3'd0, 10'd1);
    imem[1] = enc_i(3'b101, 3'd1, 10'd5);
    imem[2] = enc_i(3'b101, 3'd2, 10'd1);
    imem[3] = enc_r(3'b100, 3'd0, 3'd0);
    imem[4] = enc_r(3'b111, 3'd3, 3'd1);
    imem[5] = enc_r(3'b001, 3'd3, 3'd0);
    imem[6] = enc_r(3'b000, 3'd0, 3'd2);
    imem[7] = enc_i(3'b110, 3'd3, 10'd1);
    imem[8] = enc_i(3'b111, 3'd0, 10'h3FB);
    do_reset();
    do_start();
    outs.delete();
    first_out = 1;
    for (int k = 0; k < 80 && !halt_m; k++) begin
      step_instr(first_out ? 4 : 0);
      if (out_seen) begin
        outs.push_back(last_out);
        first_out = 0;
      end
    end
    check("prog_halted", halt_m, 1);
    check("prog_pc", imem_addr, 16'h0009);
    check("prog_nout", outs.size(), 5);
    for (int i = 0; i < outs.size() && i < 5; i++)
      check("prog_out", outs[i], i + 1);

    // start is ignored while halted
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("halt_start_h", halted, 1);
    check("halt_start_pc", imem_addr, 16'h0009);
    check("halt_start_busy", busy, 0);

    // Wrap-around jumps, REP, opcode 010 at 0x0004
    fill_mem({3'b011, 13'h0});
    imem[16'h0000] = enc_i(3'b111, 3'd0, 10'h3FF);
    imem[16'hFFFF] = enc_i(3'b111, 3'd0, 10'd2);
    imem[16'h0001] = enc_i(3'b101, 3'd0, 10'd7);
    imem[16'h0002] = enc_r(3'b111, 3'd1, 3'd0);
    imem[16'h0003] = enc_i(3'b101, 3'd2, 10'h3FF);
    imem[16'h0004] = {3'b010, 13'h1ABC};
    do_reset();
    do_start();
    step_instr(0);
    check("jmp_wrap", imem_addr, 16'hFFFF);
    for (int k = 0; k < 20 && !halt_m; k++) step_instr(0);
    check("rep_r1", dp[1], 16'd7);
    check("ldi_zext", dp[2], 16'h03FF);
`ifdef ILLEGAL_OP_TRAP_EN
    check("op010_pc", imem_addr, 16'h0004);
    check("op010_ill", illegal_op, 1);
    check("op010_ret", retired, 16'd5);
`else
    check("op010_pc", imem_addr, 16'h0005);
    check("op010_ret", retired, 16'd6);
`endif

    // rst during DECODE, then during out_valid
    fill_mem({3'b011, 13'h0});
    imem[0] = enc_i(3'b101, 3'd0, 10'd9);
    imem[1] = enc_r(3'b100, 3'd0, 3'd0);
    do_reset();
    do_start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst_dec");
    do_start();
    ret_m = 16'h0;
    step_instr(0);
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    check("pre_rst_ov", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst_out");
    ret_m = 16'h0;
    do_start();
    step_instr(0);
    check("refetch_pc", imem_addr, 16'h0001);

    // Random instruction streams
    for (int rnd = 0; rnd < 8; rnd++) begin
      for (int i = 0; i < 65536; i++) imem[i] = 16'($urandom);
      do_reset();
      do_start();
      for (int k = 0; k < 60 && !halt_m; k++)
        step_instr($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
